// File: rtl/dfu_operand_router_pkg.sv
// rtl/dfu_operand_router_pkg.sv - shared constants and types for the DFU operand router
// Purpose: geometry of the bank-to-lane router and operand/select/counter types.
// Ports: none (package dfu_pkg).
// Build option: DFU_ROUTER_ZERO_FILL_EN (see dfu_operand_router).
package dfu_pkg;
  localparam int NUM_BANKS = 4;
  localparam int NUM_LANES = 4;
  localparam int DATA_W    = 8;
  localparam int SEL_W     = 2;
  localparam int RD_LAT    = 1;
  localparam int EL_RC     = 16;
  localparam int CNT_W     = 11;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [SEL_W-1:0]  bank_sel_t;
  typedef logic [CNT_W-1:0]  beat_cnt_t;
endpackage

// File: rtl/dfu_operand_router_if.sv
// rtl/dfu_operand_router_if.sv - request/SRAM/operand bundle between DFU, banks and array edge
// Purpose: groups the DFU request, SRAM read-return and lane operand signals.
// Ports (signals):
//   mux_rd_en, lane_rd_en, lane_bank_sel : DFU request side (into router)
//   sram_rd_data, sram_rd_vld            : bank read return (into router)
//   lane_data, lane_vld, tile_done, lat_err : array-edge operand stream and status (from router)
// Modports: master = DFU/SRAM/array side, slave = router.
interface dfu_operand_router_if;
  import dfu_pkg::*;

  logic                          mux_rd_en;
  logic [NUM_LANES-1:0]          lane_rd_en;
  logic [NUM_LANES*SEL_W-1:0]    lane_bank_sel;
  logic [NUM_BANKS*DATA_W-1:0]   sram_rd_data;
  logic [NUM_BANKS-1:0]          sram_rd_vld;
  logic [NUM_LANES*DATA_W-1:0]   lane_data;
  logic [NUM_LANES-1:0]          lane_vld;
  logic                          tile_done;
  logic                          lat_err;

  modport master (
    output mux_rd_en, lane_rd_en, lane_bank_sel, sram_rd_data, sram_rd_vld,
    input  lane_data, lane_vld, tile_done, lat_err
  );

  modport slave (
    input  mux_rd_en, lane_rd_en, lane_bank_sel, sram_rd_data, sram_rd_vld,
    output lane_data, lane_vld, tile_done, lat_err
  );
endinterface

// File: rtl/dfu_operand_router_lane_delay.sv
// rtl/dfu_operand_router_lane_delay.sv - per-lane request/bank-select delay line
// Purpose: delays {req, sel} by DEPTH cycles so they line up with SRAM read data.
// Ports:
//   clk, rst (sync, active-low clear)
//   req_i, sel_i   : qualified request and bank select in
//   dreq_o, dsel_o : delayed request and bank select out
module dfu_lane_delay
  import dfu_pkg::*;
#(
  parameter int DEPTH = RD_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_i,
  input  bank_sel_t sel_i,
  output logic      dreq_o,
  output bank_sel_t dsel_o
);

  logic [DEPTH-1:0] req_q;
  bank_sel_t        sel_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q <= '0;
      for (int k = 0; k < DEPTH; k++) sel_q[k] <= '0;
    end else begin
      req_q[0] <= req_i;
      sel_q[0] <= sel_i;
      for (int k = 1; k < DEPTH; k++) begin
        req_q[k] <= req_q[k-1];
        sel_q[k] <= sel_q[k-1];
      end
    end
  end

  assign dreq_o = req_q[DEPTH-1];
  assign dsel_o = sel_q[DEPTH-1];

endmodule

// File: rtl/dfu_operand_router.sv
// rtl/dfu_operand_router.sv - routes SRAM bank data onto systolic-array lanes
// Purpose: aligns DFU requests with SRAM latency, muxes bank data per lane into a
//   registered operand stream, counts beats per lane, pulses tile_done and flags errors.
// Ports:
//   clk         : clock
//   rst         : synchronous reset, active-low
//   bus (slave) : dfu_operand_router_if (requests, SRAM return, lane operands, status)
// Build option: DFU_ROUTER_ZERO_FILL_EN - idle lanes present zero instead of holding.
module dfu_operand_router
  import dfu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dfu_operand_router_if.slave  bus
);

  localparam logic [SEL_W:0] BANK_LIMIT = (SEL_W+1)'(NUM_BANKS);

  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] dreq;
  bank_sel_t            dsel      [NUM_LANES];
  operand_t             bank_data [NUM_BANKS];
  operand_t             mux_data  [NUM_LANES];
  logic [NUM_LANES-1:0] bank_ok;

  operand_t             lane_data_q [NUM_LANES];
  operand_t             lane_data_d [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld_q;
  beat_cnt_t            cnt_q [NUM_LANES];
  beat_cnt_t            cnt_d [NUM_LANES];
  logic                 lat_err_q, lat_err_d;
  logic                 all_full;

  assign req = bus.lane_rd_en & {NUM_LANES{bus.mux_rd_en}};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dfu_lane_delay #(.DEPTH(RD_LAT)) u_delay (
      .clk    (clk),
      .rst    (rst),
      .req_i  (req[g]),
      .sel_i  (bus.lane_bank_sel[g*SEL_W +: SEL_W]),
      .dreq_o (dreq[g]),
      .dsel_o (dsel[g])
    );
  end

  // Bank mux: out-of-range selects return zero and count as an invalid read.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) bank_data[b] = bus.sram_rd_data[b*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_LANES; i++) begin
      mux_data[i] = '0;
      bank_ok[i]  = 1'b0;
      if ({1'b0, dsel[i]} < BANK_LIMIT) begin
        mux_data[i] = bank_data[dsel[i]];
        bank_ok[i]  = bus.sram_rd_vld[dsel[i]];
      end
    end
  end

  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NUM_LANES; i++)
      if (cnt_q[i] != CNT_W'(EL_RC)) all_full = 1'b0;
  end

  always_comb begin
    lat_err_d = lat_err_q;
    for (int i = 0; i < NUM_LANES; i++) begin
`ifdef DFU_ROUTER_ZERO_FILL_EN
      lane_data_d[i] = '0;
`else
      lane_data_d[i] = lane_data_q[i];
`endif
      if (dreq[i]) begin
        lane_data_d[i] = mux_data[i];
        // Beat is still delivered; only the sticky flag records the bad read.
        if (!bank_ok[i]) lat_err_d = 1'b1;
      end

      cnt_d[i] = cnt_q[i];
      if (all_full) begin
        // Tile boundary: a beat landing now belongs to the next tile.
        cnt_d[i] = lane_vld_q[i] ? CNT_W'(1) : '0;
      end else if (lane_vld_q[i]) begin
        if (cnt_q[i] == CNT_W'(EL_RC)) lat_err_d = 1'b1;
        else                           cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_vld_q <= '0;
      lat_err_q  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_data_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      lane_vld_q <= dreq;
      lat_err_q  <= lat_err_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_data_q[i] <= lane_data_d[i];
        cnt_q[i]       <= cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.lane_data = '0;
    for (int i = 0; i < NUM_LANES; i++) bus.lane_data[i*DATA_W +: DATA_W] = lane_data_q[i];
  end

  assign bus.lane_vld  = lane_vld_q;
  assign bus.tile_done = all_full;
  assign bus.lat_err   = lat_err_q;

endmodule
